telemetry_sched: RTL and testbench

Periodic telemetry scheduler for the eBike top level. It snapshots battery voltage, average motor current and pedal torque on a fixed interval. It serialises them into an 8-byte framed packet and sequences the bytes one at a time into the shared UART transmitter. The UART_rcv monitor on the bench decodes these frames.

---
 rtl/telemetry_pkg.sv | 37 +++
 rtl/telem_tmr.sv | 40 ++++
 rtl/telemetry_sched.sv | 123 ++++++++++++
 tb/tb_telemetry_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry frame scheduler.
package telemetry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [7:0]  HDR0        = 8'hAA;
  localparam logic [7:0]  HDR1        = 8'h55;
  localparam int unsigned PERIOD_FAST = 32'd4096;
  localparam int unsigned PERIOD_FULL = 32'd1048576;
  localparam int unsigned FRAME_LEN   = 32'd8;
  localparam int unsigned CNT_W       = 32'd20;

  // Byte idx of a frame built from the given snapshot values.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [11:0] batt,
                                            input logic [11:0] curr,
                                            input logic [11:0] torq);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HDR0;
      3'd1:    b = HDR1;
      3'd2:    b = {4'h0, batt[11:8]};
      3'd3:    b = batt[7:0];
      3'd4:    b = {4'h0, curr[11:8]};
      3'd5:    b = curr[7:0];
      3'd6:    b = {4'h0, torq[11:8]};
      3'd7:    b = torq[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/telem_tmr.sv
// Interval counter: held at zero while disabled, emits tick on the last count and wraps.
module telem_tmr
  import telemetry_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = FAST_SIM ? CNT_W'(PERIOD_FAST - 32'd1)
                                               : CNT_W'(PERIOD_FULL - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/telemetry_sched.sv
// Periodic telemetry scheduler: snapshots three readings on each interval tick and
// sequences an 8-byte framed packet into the UART transmitter one byte at a time.
module telemetry_sched
  import telemetry_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] batt,
  input  logic [11:0] avg_curr,
  input  logic [11:0] torque,
  input  logic        tx_done,
  input  logic        clr_ovr,
  output logic [7:0]  tx_data,
  output logic        trmt,
  output logic        busy,
  output logic        overrun
);

  logic        tick;
  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [11:0] batt_q, batt_d;
  logic [11:0] curr_q, curr_d;
  logic [11:0] torq_q, torq_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  byte_mux;

  telem_tmr #(.FAST_SIM(FAST_SIM)) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    batt_d  = batt_q;
    curr_d  = curr_q;
    torq_d  = torq_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_LOAD;
          idx_d   = 3'd0;
          batt_d  = batt;
          curr_d  = avg_curr;
          torq_d  = torque;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!tx_done) begin
          state_d = ST_WAIT;
        end else if (idx_q == 3'(FRAME_LEN - 32'd1)) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they are valid in the LOAD cycle itself.
  always_comb begin
    byte_mux  = frame_byte(idx_d, batt_d, curr_d, torq_d);
    trmt_d    = (state_d == ST_LOAD);
    busy_d    = (state_d != ST_IDLE);
    tx_data_d = tx_data_q;
    if (state_d == ST_LOAD) begin
      tx_data_d = byte_mux;
    end else begin
      tx_data_d = tx_data_q;
    end
    if (tick && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      batt_q    <= 12'h000;
      curr_q    <= 12'h000;
      torq_q    <= 12'h000;
      tx_data_q <= 8'h00;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      batt_q    <= batt_d;
      curr_q    <= curr_d;
      torq_q    <= torq_d;
      tx_data_q <= tx_data_d;
      trmt_q    <= trmt_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign tx_data = tx_data_q;
  assign trmt    = trmt_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_telemetry_sched.sv
// Scoreboard bench for telemetry_sched: stimulus queues expected frame bytes, a monitor
// pops and compares on every trmt, and a UART model answers each trmt with tx_done.
module tb_telemetry_sched;

  logic        clk = 1'b0;
  logic        rst, en, clr_ovr;
  logic        tx_done;
  logic        tx_done_u = 1'b0;
  logic        tx_done_s = 1'b0;
  logic [11:0] batt, avg_curr, torque;
  logic [7:0]  tx_data;
  logic        trmt, busy, overrun;

  int          n_chk = 0;
  int          n_fail = 0;
  int          nbytes = 0;
  int          total_trmt = 0;
  int          cyc = 0;
  int          uart_dly = 10;
  logic        prev_trmt = 1'b0;
  logic [8:0]  exp_q[$];
  int          starts_q[$];
  logic [8:0]  e;

  assign tx_done = tx_done_u | tx_done_s;

  always #5 clk = ~clk;

  telemetry_sched #(.FAST_SIM(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .batt     (batt),
    .avg_curr (avg_curr),
    .torque   (torque),
    .tx_done  (tx_done),
    .clr_ovr  (clr_ovr),
    .tx_data  (tx_data),
    .trmt     (trmt),
    .busy     (busy),
    .overrun  (overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected bytes of one frame; bit 8 marks the first byte.
  task automatic push_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    exp_q.push_back({1'b1, 8'hAA});
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 4'h0, b[11:8]});
    exp_q.push_back({1'b0, b[7:0]});
    exp_q.push_back({1'b0, 4'h0, c[11:8]});
    exp_q.push_back({1'b0, c[7:0]});
    exp_q.push_back({1'b0, 4'h0, t[11:8]});
    exp_q.push_back({1'b0, t[7:0]});
  endtask

  function automatic int gap(input int a, input int b);
    if (starts_q.size() > b) return starts_q[b] - starts_q[a];
    else return -1;
  endfunction

  task automatic wait_bytes(input int n, input int limit, input string name);
    int k = 0;
    while (nbytes < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (nbytes < n) check(name, nbytes, n);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  // Monitor: every trmt must match the next queued byte.
  always @(negedge clk) begin
    if (!rst && trmt) begin
      total_trmt++;
      check("trmt_single_cycle", prev_trmt, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_trmt", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", tx_data, e[7:0]);
        check("busy_in_load", busy, 1'b1);
        if (e[8]) starts_q.push_back(cyc);
        nbytes++;
      end
    end
    prev_trmt = trmt;
  end

  // UART model: tx_done uart_dly cycles after each trmt, abandoned on reset.
  initial begin
    forever begin
      @(negedge clk);
      if (trmt && !rst) begin
        automatic int d = uart_dly;
        automatic bit aborted = 1'b0;
        for (int i = 0; i < d; i++) begin
          @(posedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          #1 tx_done_u = 1'b1;
          @(posedge clk);
          #1 tx_done_u = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    int t0;
    rst = 1'b1; en = 1'b0; clr_ovr = 1'b0;
    batt = 12'h000; avg_curr = 12'h000; torque = 12'h000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_trmt", trmt, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // Spurious tx_done while idle
    @(posedge clk); #1 tx_done_s = 1'b1;
    @(posedge clk); #1 tx_done_s = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_no_trmt", total_trmt, 0);
    check("idle_tx_data", tx_data, 8'h00);

    // Basic frame, then snapshot isolation across frames 2 and 3
    batt = 12'hB80; avg_curr = 12'h3A5; torque = 12'h700;
    push_frame(12'hB80, 12'h3A5, 12'h700);
    push_frame(12'hB80, 12'h3A5, 12'h700);
    push_frame(12'hB80, 12'h3A5, 12'h500);
    @(posedge clk); #1 en = 1'b1;
    n = 0;
    while (n < 5000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (trmt) break;
    end
    check("first_trmt_latency", n, 4096);
    wait_bytes(8, 2000, "frame1_bytes");
    wait_idle(200, "frame1_idle");
    check("tx_data_hold", tx_data, 8'h00);
    wait_bytes(11, 6000, "frame2_byte2");
    @(posedge clk); #1 torque = 12'h500;
    wait_bytes(24, 10000, "frame3_bytes");
    wait_idle(200, "frame3_idle");
    check("tick_period", gap(0, 1), 4096);
    check("ovr_clear_normal", overrun, 1'b0);

    // Overrun: slow UART stretches the frame past one interval
    uart_dly = 600;
    push_frame(12'hB80, 12'h3A5, 12'h500);
    wait_bytes(32, 12000, "frame4_bytes");
    wait_idle(1000, "frame4_idle");
    check("ovr_set", overrun, 1'b1);
    uart_dly = 10;
    push_frame(12'hB80, 12'h3A5, 12'h500);
    wait_bytes(40, 6000, "frame5_bytes");
    wait_idle(200, "frame5_idle");
    check("dropped_tick_not_queued", gap(3, 4), 8192);
    check("ovr_sticky", overrun, 1'b1);
    @(posedge clk); #1 clr_ovr = 1'b1;
    @(posedge clk); #1 clr_ovr = 1'b0;
    @(negedge clk);
    check("ovr_cleared", overrun, 1'b0);

    // en dropped after byte 3: frame completes, then silence
    batt = 12'h123;
    push_frame(12'h123, 12'h3A5, 12'h500);
    wait_bytes(44, 6000, "frame6_byte3");
    @(posedge clk); #1 en = 1'b0;
    wait_bytes(48, 300, "frame6_bytes");
    wait_idle(200, "frame6_idle");
    t0 = total_trmt;
    repeat (10000) @(posedge clk);
    @(negedge clk);
    check("no_trmt_en_low", total_trmt - t0, 0);
    check("busy_en_low", busy, 1'b0);

    // Reset during WAIT on byte 5
    push_frame(12'h123, 12'h3A5, 12'h500);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    @(posedge clk); #1 en = 1'b1;
    wait_bytes(54, 6000, "frame7_byte5");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_trmt", trmt, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    t0 = total_trmt;
    @(posedge clk); #1 tx_done_s = 1'b1;
    @(posedge clk); #1 tx_done_s = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stray_done_no_trmt", total_trmt - t0, 0);
    check("stray_done_busy", busy, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
